tx_path: RTL and testbench
==========================

Name: tx_path

Overview:
- Serial transmitter that pairs with the team's serial receive path.
- Takes a parallel word on a start handshake and shifts out one frame on a single line.
- Frame order: start bit (0), data LSB first, an optional even-parity bit after each 8-bit data group, then stop bit(s) (1).
- Sits between the host-side register interface and the serial pin; the line idles high.

Parameters:
- WIDTH_SIZE, 8: data word width in bits; any value 1..32.
- CLKS_PER_BIT, 1: clk cycles each serial bit is held; 1 gives one bit per clk, which matches the receive path's sampling.
- STOP_BITS, 1: number of stop bits per frame; 1 or 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to send data_in; sampled only while ready=1.
- PF  input  1  parity enable, captured together with data_in.
- data_in  input  WIDTH_SIZE  word to transmit.
- Tx  output  1  serial line; idles high.
- ready  output  1  high while idle and able to accept start.
- busy  output  1  high from the first start-bit cycle through the last stop-bit cycle.
- done  output  1  one-cycle pulse in the last clk cycle of the last stop bit.

Behaviour:
- Clock and reset: one clock domain. reset is asynchronous, active-low.
- Reset values: Tx=1, ready=1, busy=0, done=0; state=IDLE; all counters, shift register and parity accumulator cleared. Reset asserted mid-frame aborts the frame immediately (Tx=1 asynchronously); the partial frame is not resumed.
- States:
  - IDLE: Tx=1, ready=1, busy=0. If start=1, capture data_in into the shift register and PF into pf_q, clear the parity accumulator, go to START. start while not IDLE is ignored, not queued.
  - START: Tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: Tx=shift_reg[0] for CLKS_PER_BIT cycles per bit. At each bit end, shift right and XOR the bit into the parity accumulator; bit_cnt and group_cnt increment.
    - When group_cnt reaches 8 and pf_q=1: go to PARITY.
    - When bit_cnt reaches WIDTH_SIZE: go to PARITY if pf_q=1 and group_cnt!=0, otherwise go to STOP.
  - PARITY: Tx=accumulator (even parity: XOR of the group's bits) for CLKS_PER_BIT cycles. Then clear the accumulator and group_cnt; return to DATA if bits remain, else go to STOP.
  - STOP: Tx=1 for STOP_BITS*CLKS_PER_BIT cycles. done=1 in the final cycle, then go to IDLE.
- Frame length in bits: 1 + WIDTH_SIZE + (pf_q ? ceil(WIDTH_SIZE/8) : 0) + STOP_BITS.
- Latency: Tx falls in the cycle after start is accepted. Back-to-back frames are separated by at least one IDLE cycle with Tx=1, giving the receiver its idle-detection cycle.
- Register behaviour: data_in and PF changes after capture have no effect on the frame in flight. Tx is driven from a register, so the line is glitch-free.
- Widths: bit_cnt holds up to WIDTH_SIZE; group_cnt is 4 bits; the baud counter is clog2(CLKS_PER_BIT)+1 bits and wraps to 0 at each bit end.

Decomposition:
- Shared package uart_pkg: the state enum (IDLE, START, DATA, PARITY, STOP) and a PARITY_GROUP=8 constant. The enum is shared with the receive path.
- One sub-module: baud_tick, a CLKS_PER_BIT down-counter that produces a bit_end strobe. It is reloaded on state entry and is a constant 1 when CLKS_PER_BIT=1.

Test Plan:
- WIDTH_SIZE=8, CLKS_PER_BIT=1, data_in=8'hA5, PF=1, start pulse -> Tx from the next cycle: 0,1,0,1,0,0,1,0,1,0,1 (11 bits); busy high for exactly 11 cycles; done on the 11th; Tx=1 after.
- Same frame with PF=0 -> Tx: 0,1,0,1,0,0,1,0,1,1 (10 bits); no parity slot.
- WIDTH_SIZE=16, data_in=16'h1234, PF=1 -> parity 1 after the low byte (0x34, three ones) and 0 after the high byte (0x12, two ones); 20-bit frame.
- Loopback into the receive path for 0x00, 0xFF, 0x5A with PF=1 -> received data matches each word, err=0, valid pulses once per frame.
- start re-asserted every cycle while busy, and data_in changed mid-frame -> exactly one frame per accept, carrying the captured word; ready=0 throughout.
- reset deasserted then reasserted during DATA bit 4 of 0xA5 -> Tx=1, busy=0, done never pulses; the next start sends a complete, correct frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Definitions shared by the serial transmit and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // An even-parity bit follows every group of this many data bits.
    localparam int PARITY_GROUP = 8;

endpackage

// File: rtl/baud_tick.sv
// Bit-period timer: strobes o_bit_end in the last clk cycle of each serial bit.
module baud_tick #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_reload,
    output logic o_bit_end
);

    localparam int               CNT_W   = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    // With CLKS_PER_BIT=1 the counter is pinned at zero, so the strobe is constant 1.
    assign o_bit_end = (r_cnt == '0);

    // NOTE: state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_reload || o_bit_end) begin
            r_cnt <= CNT_TOP;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/tx_path.sv
// Serial transmitter: start bit, LSB-first data with optional even parity per
// 8-bit group, then stop bit(s). The line idles high and Tx comes from a register.
module tx_path
    import uart_pkg::*;
#(
    parameter int WIDTH_SIZE   = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  PF,
    input  logic [WIDTH_SIZE-1:0] data_in,
    output logic                  Tx,
    output logic                  ready,
    output logic                  busy,
    output logic                  done
);

    localparam int               BIT_W      = $clog2(WIDTH_SIZE + 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WIDTH_SIZE - 1);
    localparam logic [BIT_W-1:0] BIT_ALL    = BIT_W'(WIDTH_SIZE);
    localparam logic [3:0]       GROUP_LAST = 4'(PARITY_GROUP - 1);
    localparam logic             STOP_LAST  = 1'(STOP_BITS - 1);

    uart_state_e           r_state;
    uart_state_e           w_state_nxt;
    logic [WIDTH_SIZE-1:0] r_shift;
    logic [WIDTH_SIZE-1:0] w_shift_nxt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [3:0]            r_group_cnt;
    logic                  r_stop_cnt;
    logic                  r_pf_q;
    logic                  r_acc;
    logic                  w_acc_nxt;
    logic                  r_tx;
    logic                  w_tx_nxt;
    logic                  w_bit_end;
    logic                  w_reload;
    logic                  w_accept;
    logic                  w_data_last;
    logic                  w_group_last;
    logic                  w_stop_last;

    assign w_reload     = (r_state == IDLE);
    assign w_accept     = (r_state == IDLE) && start;
    assign w_data_last  = (r_bit_cnt == BIT_LAST);
    assign w_group_last = (r_group_cnt == GROUP_LAST);
    assign w_stop_last  = (r_stop_cnt == STOP_LAST);

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk      (clk),
        .rst_n    (reset),
        .i_reload (w_reload),
        .o_bit_end(w_bit_end)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = START;
            end
            START: begin
                if (w_bit_end) w_state_nxt = DATA;
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_pf_q && (w_group_last || w_data_last)) begin
                        w_state_nxt = PARITY;
                    end else if (w_data_last) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) w_state_nxt = (r_bit_cnt == BIT_ALL) ? STOP : DATA;
            end
            STOP: begin
                if (w_bit_end && w_stop_last) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next shift/parity values feed the Tx register, so Tx shows the next bit at the edge.
    always_comb begin
        w_shift_nxt = r_shift;
        w_acc_nxt   = r_acc;
        if (w_accept) begin
            w_shift_nxt = data_in;
            w_acc_nxt   = 1'b0;
        end else if (w_bit_end && r_state == DATA) begin
            w_shift_nxt = r_shift >> 1;
            w_acc_nxt   = r_acc ^ r_shift[0];
        end else if (w_bit_end && r_state == PARITY) begin
            w_acc_nxt   = 1'b0;
        end

        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shift_nxt[0];
            PARITY:  w_tx_nxt = w_acc_nxt;
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift     <= '0;
            r_acc       <= 1'b0;
            r_pf_q      <= 1'b0;
            r_bit_cnt   <= '0;
            r_group_cnt <= '0;
            r_stop_cnt  <= 1'b0;
            r_tx        <= 1'b1;
        end else begin
            r_shift <= w_shift_nxt;
            r_acc   <= w_acc_nxt;
            r_tx    <= w_tx_nxt;
            if (w_accept) begin
                r_pf_q      <= PF;
                r_bit_cnt   <= '0;
                r_group_cnt <= '0;
                r_stop_cnt  <= 1'b0;
            end else if (w_bit_end) begin
                case (r_state)
                    DATA: begin
                        r_bit_cnt   <= r_bit_cnt + 1'b1;
                        r_group_cnt <= r_group_cnt + 1'b1;
                    end
                    PARITY:  r_group_cnt <= '0;
                    STOP:    r_stop_cnt  <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        Tx    = r_tx;
        ready = (r_state == IDLE);
        busy  = (r_state != IDLE);
        done  = (r_state == STOP) && w_bit_end && w_stop_last;
    end

endmodule

// File: tb/tb_tx_path.sv
// Scoreboarded bench for tx_path: three configurations, each decoded cycle by cycle
// against a frame built from the bit-order rules.
module tb_tx_path;

    localparam int N = 3;
    localparam int P_W [N] = '{8, 16, 13};
    localparam int P_C [N] = '{1, 1, 3};
    localparam int P_S [N] = '{1, 1, 2};

    typedef struct {
        logic [31:0] data;
        logic        pf;
        bit          abort;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] start;
    logic [N-1:0] pf;
    logic [31:0]  data_v [N];
    wire  [N-1:0] tx;
    wire  [N-1:0] ready;
    wire  [N-1:0] busy;
    wire  [N-1:0] done;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    tx_path #(.WIDTH_SIZE(8), .CLKS_PER_BIT(1), .STOP_BITS(1)) u_dut8 (
        .clk(clk), .reset(rst_n), .start(start[0]), .PF(pf[0]), .data_in(data_v[0][7:0]),
        .Tx(tx[0]), .ready(ready[0]), .busy(busy[0]), .done(done[0])
    );
    tx_path #(.WIDTH_SIZE(16), .CLKS_PER_BIT(1), .STOP_BITS(1)) u_dut16 (
        .clk(clk), .reset(rst_n), .start(start[1]), .PF(pf[1]), .data_in(data_v[1][15:0]),
        .Tx(tx[1]), .ready(ready[1]), .busy(busy[1]), .done(done[1])
    );
    tx_path #(.WIDTH_SIZE(13), .CLKS_PER_BIT(3), .STOP_BITS(2)) u_dut13 (
        .clk(clk), .reset(rst_n), .start(start[2]), .PF(pf[2]), .data_in(data_v[2][12:0]),
        .Tx(tx[2]), .ready(ready[2]), .busy(busy[2]), .done(done[2])
    );

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %b required %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void q_push(input int i, input exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int q_size(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t q_pop(input int i);
        case (i)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Line bits of one frame, one entry per serial bit; returns the bit count.
    function automatic int frame_model(input int w, input int s, input exp_t e,
                                       output logic [63:0] f);
        int   n   = 0;
        logic par = 1'b0;
        f = '1;
        f[n] = 1'b0;
        n++;
        for (int b = 0; b < w; b++) begin
            f[n] = e.data[b];
            n++;
            par ^= e.data[b];
            if (e.pf && ((b % 8) == 7 || b == w - 1)) begin
                f[n] = par;
                n++;
                par = 1'b0;
            end
        end
        return n + s;
    endfunction

    task automatic run_monitor(input int i);
        exp_t        e;
        logic [63:0] f;
        int          nb;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx[i] === 1'b0) begin
                if (q_size(i) == 0) begin
                    check("unexpected_frame", 1'b1, 1'b0);
                    while (busy[i] === 1'b1 && rst_n === 1'b1) @(negedge clk);
                end else begin
                    e       = q_pop(i);
                    nb      = frame_model(P_W[i], P_S[i], e, f);
                    aborted = 1'b0;
                    for (int k = 0; k < nb * P_C[i] && !aborted; k++) begin
                        if (k != 0) @(negedge clk);
                        if (rst_n !== 1'b1) begin
                            aborted = 1'b1;
                        end else begin
                            check("tx_bit", tx[i], f[k / P_C[i]]);
                            check("busy_frame", busy[i], 1'b1);
                            check("ready_frame", ready[i], 1'b0);
                            check("done_pulse", done[i], k == nb * P_C[i] - 1);
                        end
                    end
                    if (aborted) begin
                        check("abort_expected", e.abort, 1'b1);
                        check("tx_in_reset", tx[i], 1'b1);
                        check("busy_in_reset", busy[i], 1'b0);
                        check("done_in_reset", done[i], 1'b0);
                    end else begin
                        check("abort_missed", e.abort, 1'b0);
                        @(negedge clk);
                        if (rst_n === 1'b1) begin
                            check("idle_tx", tx[i], 1'b1);
                            check("idle_ready", ready[i], 1'b1);
                            check("idle_busy", busy[i], 1'b0);
                            check("idle_done", done[i], 1'b0);
                        end
                    end
                end
            end
        end
    endtask

    initial run_monitor(0);
    initial run_monitor(1);
    initial run_monitor(2);

    // Called at a negedge; returns at the negedge of the first start-bit cycle,
    // or of the idle cycle that ends the frame when hold is set.
    task automatic send(input int i, input logic [31:0] d, input logic p,
                        input bit ab, input bit hold);
        exp_t e;
        int   t = 0;
        while (ready[i] !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", ready[i], 1'b1);
        start[i]  = 1'b1;
        data_v[i] = d;
        pf[i]     = p;
        e.data    = d;
        e.pf      = p;
        e.abort   = ab;
        q_push(i, e);
        @(negedge clk);
        check("start_latency_tx", tx[i], 1'b0);
        check("start_latency_busy", busy[i], 1'b1);
        if (hold) begin
            t = 0;
            while (ready[i] !== 1'b1 && t < 500) begin
                data_v[i] = $urandom;
                pf[i]     = 1'($urandom_range(0, 1));
                @(negedge clk);
                t++;
            end
            check("hold_end_ready", ready[i], 1'b1);
        end
        start[i]  = 1'b0;
        data_v[i] = $urandom;
        pf[i]     = 1'($urandom_range(0, 1));
    endtask

    task automatic random_stream(input int i, input int count);
        for (int k = 0; k < count; k++) begin
            send(i, $urandom, 1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (t < 3000 && !(ready === '1 && q0.size() == 0 && q1.size() == 0
                             && q2.size() == 0)) begin
            @(negedge clk);
            t++;
        end
        check("drain_in_time", t < 3000, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        start = '0;
        pf    = '0;
        for (int i = 0; i < N; i++) data_v[i] = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check("reset_tx", tx[i], 1'b1);
            check("reset_ready", ready[i], 1'b1);
            check("reset_busy", busy[i], 1'b0);
            check("reset_done", done[i], 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Directed frames: parity on/off, 16-bit two-group parity, loopback patterns.
        send(0, 32'h0000_00A5, 1'b1, 1'b0, 1'b0);
        send(0, 32'h0000_00A5, 1'b0, 1'b0, 1'b0);
        send(1, 32'h0000_1234, 1'b1, 1'b0, 1'b0);
        send(0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        send(0, 32'h0000_00FF, 1'b1, 1'b0, 1'b0);
        send(0, 32'h0000_005A, 1'b1, 1'b0, 1'b0);
        send(2, 32'h0000_1FFF, 1'b1, 1'b0, 1'b0);
        send(2, 32'h0000_0AAA, 1'b0, 1'b0, 1'b0);
        wait_idle();

        // start held high with data_in churning while busy.
        send(0, 32'h0000_003C, 1'b1, 1'b0, 1'b1);
        send(2, 32'h0000_1555, 1'b1, 1'b0, 1'b1);
        wait_idle();

        fork
            random_stream(0, 30);
            random_stream(1, 25);
            random_stream(2, 15);
        join
        wait_idle();

        // Reset during DATA bit 4 of 0xA5, then a clean frame.
        send(0, 32'h0000_00A5, 1'b1, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("async_abort_tx", tx[0], 1'b1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", ready[0], 1'b1);
        send(0, 32'h0000_00A5, 1'b1, 1'b0, 1'b0);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
